// File: rtl/mux_rr.sv
// N-channel valid-only multiplexer: per-channel FIFOs feed a round-robin arbiter
// that loads a registered ready/valid output stage.
module mux_rr #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        valid_in,
  input  logic                     ready_out,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic [CH_W-1:0]          ch_out,
  output logic [NUM_CH-1:0]        fifo_full,
  output logic [NUM_CH-1:0]        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q  [NUM_CH][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d  [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q [NUM_CH];
  logic [PTR_W-1:0]  wptr_d [NUM_CH];
  logic [PTR_W-1:0]  rptr_q [NUM_CH];
  logic [PTR_W-1:0]  rptr_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];

  logic [NUM_CH-1:0] full_q, full_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              vout_q, vout_d;

  logic              load;
  logic              found;
  logic [CH_W-1:0]   sel;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] wr;

  // Arbiter only looks at pre-edge counts, so a word written this edge waits a cycle.
  always_comb begin
    load  = !vout_q || ready_out;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && cnt_q[(int'(rr_q) + k) % NUM_CH] != '0) begin
        found = 1'b1;
        sel   = CH_W'((int'(rr_q) + k) % NUM_CH);
      end
    end
    pop = '0;
    if (load && found) pop[sel] = 1'b1;
  end

  always_comb begin
    dout_d = dout_q;
    ch_d   = ch_q;
    vout_d = vout_q;
    rr_d   = rr_q;
    if (load) begin
      if (found) begin
        dout_d = mem_q[sel][rptr_q[sel]];
        ch_d   = sel;
        vout_d = 1'b1;
        rr_d   = CH_W'((int'(sel) + 1) % NUM_CH);
      end else begin
        vout_d = 1'b0;
      end
    end
  end

  // A full FIFO still accepts a write when the same channel is popped this cycle.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    full_d = '0;
    wr     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = valid_in[i] && (cnt_q[i] != CNT_W'(FIFO_DEPTH) || pop[i]);
      if (valid_in[i] && !wr[i]) ovf_d[i] = 1'b1;
      if (wr[i]) begin
        mem_d[i][wptr_q[i]] = data_in[i*DATA_W +: DATA_W];
        wptr_d[i]           = wptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) rptr_d[i] = rptr_q[i] + PTR_W'(1);
      case ({wr[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      full_d[i] = (cnt_d[i] == CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_CH; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      full_q <= '0;
      ovf_q  <= '0;
      dout_q <= '0;
      ch_q   <= '0;
      rr_q   <= '0;
      vout_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
      dout_q <= dout_d;
      ch_q   <= ch_d;
      rr_q   <= rr_d;
      vout_q <= vout_d;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign ch_out    = ch_q;
  assign fifo_full = full_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mux_rr.sv
// Bench for mux_rr: constant vector table, hand-written multi-cycle sequences,
// and random traffic checked against a queue-based reference model.
module tb_mux_rr;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  logic        clk;
  logic        reset_L;
  logic [15:0] data_in;
  logic [3:0]  valid_in;
  logic        ready_out;
  logic [3:0]  data_out;
  logic        valid_out;
  logic [1:0]  ch_out;
  logic [3:0]  fifo_full;
  logic [3:0]  overflow;

  int compared   = 0;
  int mismatched = 0;

  mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ch_out    (ch_out),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per channel plus the output register contents.
  logic [3:0] mq [NUM_CH][$];
  logic       m_valid;
  logic [3:0] m_data;
  int         m_ch;
  int         m_rr;
  logic [3:0] m_ovf;

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) mq[i].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_rr    = 0;
    m_ovf   = '0;
  endtask

  task automatic model_step();
    int picked;
    if (!reset_L) return;
    picked = -1;
    if (!m_valid || ready_out) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_rr + k) % NUM_CH;
        if (picked < 0 && mq[c].size() > 0) picked = c;
      end
      if (picked >= 0) begin
        m_data  = mq[picked].pop_front();
        m_ch    = picked;
        m_valid = 1'b1;
        m_rr    = (picked + 1) % NUM_CH;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (valid_in[i]) begin
        if (mq[i].size() < DEPTH || i == picked) mq[i].push_back(data_in[i*4 +: 4]);
        else m_ovf[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [3:0] model_full();
    logic [3:0] f;
    for (int i = 0; i < NUM_CH; i++) f[i] = (mq[i].size() == DEPTH);
    return f;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] vin, input logic [15:0] din, input logic rdy);
    valid_in  = vin;
    data_in   = din;
    ready_out = rdy;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    checkOutput({tag, " valid_out"}, 32'(valid_out), 0);
    checkOutput({tag, " data_out"},  32'(data_out),  0);
    checkOutput({tag, " ch_out"},    32'(ch_out),    0);
    checkOutput({tag, " fifo_full"}, 32'(fifo_full), 0);
    checkOutput({tag, " overflow"},  32'(overflow),  0);
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, " valid_out"}, 32'(valid_out), 32'(m_valid));
    checkOutput({tag, " data_out"},  32'(data_out),  32'(m_data));
    checkOutput({tag, " ch_out"},    32'(ch_out),    32'(m_ch));
    checkOutput({tag, " fifo_full"}, 32'(fifo_full), 32'(model_full()));
    checkOutput({tag, " overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  task automatic reset_dut(input bit check_vals);
    reset_L = 1'b0;
    model_clear();
    for (int c = 0; c < 2; c++) begin
      valid_in  = 4'($urandom);
      data_in   = 16'($urandom);
      ready_out = 1'($urandom);
      tick();
      if (check_vals) check_cleared($sformatf("reset cycle %0d", c));
    end
    valid_in  = '0;
    data_in   = '0;
    ready_out = 1'b0;
    reset_L   = 1'b1;
  endtask

  typedef struct {
    bit         do_reset;
    logic [3:0] vin;
    logic [15:0] din;
    logic       rdy;
    logic       ev;
    logic [3:0] ed;
    logic [1:0] ech;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset_L   = 1'b1;
    valid_in  = '0;
    data_in   = '0;
    ready_out = 1'b0;
    model_clear();
    #1;
    reset_L = 1'b0;
    #1;
    check_cleared("reset async");
    reset_dut(1'b1);

    // Expected values are the outputs after the edge that samples each row.
    vecs.push_back('{1, 4'b0100, 16'h0A00, 1, 0, 4'h0, 2'd0});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 1, 4'hA, 2'd2});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 0, 4'hA, 2'd2});
    vecs.push_back('{1, 4'b1111, 16'h4321, 1, 0, 4'h0, 2'd0});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 1, 4'h1, 2'd0});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 1, 4'h2, 2'd1});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 1, 4'h3, 2'd2});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 1, 4'h4, 2'd3});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 0, 4'h4, 2'd3});
    vecs.push_back('{0, 4'b1111, 16'h8765, 1, 0, 4'h4, 2'd3});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 1, 4'h5, 2'd0});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 1, 4'h6, 2'd1});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 1, 4'h7, 2'd2});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 1, 4'h8, 2'd3});
    vecs.push_back('{0, 4'b0000, 16'h0000, 1, 0, 4'h8, 2'd3});

    foreach (vecs[n]) begin
      if (vecs[n].do_reset) reset_dut(1'b0);
      applyStimulus(vecs[n].vin, vecs[n].din, vecs[n].rdy);
      checkOutput($sformatf("vec%0d valid_out", n), 32'(valid_out), 32'(vecs[n].ev));
      checkOutput($sformatf("vec%0d data_out", n),  32'(data_out),  32'(vecs[n].ed));
      checkOutput($sformatf("vec%0d ch_out", n),    32'(ch_out),    32'(vecs[n].ech));
    end

    // Backpressure: ch1 writes 5,6,7 while the sink stalls.
    reset_dut(1'b0);
    applyStimulus(4'b0010, 16'h0050, 1'b0);
    checkOutput("bp first valid_out", 32'(valid_out), 0);
    applyStimulus(4'b0010, 16'h0060, 1'b0);
    applyStimulus(4'b0010, 16'h0070, 1'b0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b0000, 16'h0000, 1'b0);
      checkOutput($sformatf("bp hold%0d valid_out", c), 32'(valid_out), 1);
      checkOutput($sformatf("bp hold%0d data_out", c), 32'(data_out), 5);
      checkOutput($sformatf("bp hold%0d ch_out", c), 32'(ch_out), 1);
      checkOutput($sformatf("bp hold%0d fifo_full1", c), 32'(fifo_full[1]), 0);
    end
    for (int w = 6; w <= 7; w++) begin
      applyStimulus(4'b0000, 16'h0000, 1'b1);
      checkOutput($sformatf("bp drain%0d valid_out", w), 32'(valid_out), 1);
      checkOutput($sformatf("bp drain%0d data_out", w), 32'(data_out), 32'(w));
    end
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    checkOutput("bp empty valid_out", 32'(valid_out), 0);

    // Overflow: ch3 writes 8..D under full backpressure.
    reset_dut(1'b0);
    for (int w = 8; w <= 13; w++) begin
      applyStimulus(4'b1000, 16'(w) << 12, 1'b0);
      if (w == 12) begin
        checkOutput("ovf full after C", 32'(fifo_full[3]), 1);
        checkOutput("ovf clear after C", 32'(overflow), 0);
      end
    end
    checkOutput("ovf set after D", 32'(overflow), 32'h8);
    checkOutput("ovf still full", 32'(fifo_full[3]), 1);
    checkOutput("ovf head data_out", 32'(data_out), 8);
    for (int w = 9; w <= 12; w++) begin
      applyStimulus(4'b0000, 16'h0000, 1'b1);
      checkOutput($sformatf("ovf drain%0h data_out", w), 32'(data_out), 32'(w));
      checkOutput($sformatf("ovf drain%0h ch_out", w), 32'(ch_out), 3);
      checkOutput($sformatf("ovf drain%0h valid_out", w), 32'(valid_out), 1);
    end
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    checkOutput("ovf dropped word valid_out", 32'(valid_out), 0);
    checkOutput("ovf sticky", 32'(overflow), 32'h8);

    // Reset pulse between edges while ch0 has three words queued.
    reset_dut(1'b0);
    for (int w = 1; w <= 4; w++) applyStimulus(4'b0001, 16'(w), 1'b0);
    checkOutput("midrst pre valid_out", 32'(valid_out), 1);
    checkOutput("midrst pre data_out", 32'(data_out), 1);
    #2;
    reset_L = 1'b0;
    model_clear();
    #1;
    check_cleared("midrst async");
    #1;
    reset_L = 1'b1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b0000, 16'h0000, 1'b1);
      checkOutput($sformatf("midrst post%0d valid_out", c), 32'(valid_out), 0);
    end

    // Random traffic against the reference model, light then heavy backpressure.
    reset_dut(1'b0);
    for (int c = 0; c < 3000; c++) begin
      logic rdy;
      if (c < 1500) rdy = ($urandom_range(0, 3) != 0);
      else          rdy = ($urandom_range(0, 3) == 0);
      applyStimulus(4'($urandom & $urandom), 16'($urandom), rdy);
      check_model($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_rr.md
# mux_rr

Parametrised N-channel valid-qualified multiplexer with per-channel input FIFOs, round-robin arbitration and a ready/valid output stage. It generalises the two-input valid mux to NUM_CH channels of DATA_W bits. It buffers bursts per channel, reports overflow, and honours downstream backpressure. It sits between independent valid-only sources and a single shared ready/valid sink.

## Interface
Parameters:
- NUM_CH, default 4: number of input channels, at least 2.
- DATA_W, default 4: data width per channel.
- FIFO_DEPTH, default 4: entries per channel FIFO, power of 2, at least 2.
- CH_W, default $clog2(NUM_CH): width of the channel-id output.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous active-low reset. Assertion clears all state immediately; release is sampled synchronously.
- data_in  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- valid_in  in  NUM_CH  per-channel write strobe. There is no input ready; sources never stall.
- ready_out  in  1  downstream accepts data_out this cycle.
- data_out  out  DATA_W  registered output word.
- valid_out  out  1  data_out and ch_out are valid.
- ch_out  out  CH_W  source channel of data_out.
- fifo_full  out  NUM_CH  per-channel FIFO occupancy is FIFO_DEPTH (pre-edge state).
- overflow  out  NUM_CH  sticky; set when a channel write is dropped.

## Operation
- **Per-channel FIFO**
  - Each channel has a FIFO with a count from 0 to FIFO_DEPTH and wrapping read/write pointers of $clog2(FIFO_DEPTH) bits.
  - A write is accepted when valid_in[i] is high and either count < FIFO_DEPTH or the same channel is popped this cycle.
  - Otherwise the word is dropped and overflow[i] is set. overflow[i] stays set until reset.
  - A simultaneous write and pop leaves the count unchanged.
- **Output register advance**
  - The output register may load when valid_out is 0 or ready_out is 1.
- **Arbiter** (evaluated only when the output register may load)
  - Scan channels rr_ptr, rr_ptr+1, … modulo NUM_CH and select the first channel with pre-edge count > 0.
  - On selection: pop that FIFO, load data_out and ch_out, set valid_out=1, and set rr_ptr to (selected+1) mod NUM_CH.
  - If no channel is non-empty: valid_out goes to 0. data_out and ch_out hold their last values. rr_ptr is unchanged.
- **Backpressure:** while valid_out=1 and ready_out=0, data_out, ch_out and valid_out hold, and no FIFO is popped.
- **Write-then-read ordering:** a word written into an empty FIFO at edge k is not eligible for selection until edge k+1. There is no bypass path.
- **Reset**
  - Asserting reset_L at any time, including mid-burst or during backpressure, asynchronously clears state.
  - Outputs and state after reset: valid_out=0, data_out=0, ch_out=0, overflow=0, all FIFO counts and pointers=0, rr_ptr=0.
  - fifo_full reads 0 after reset.
  - FIFO contents are discarded.

## Timing
- **Minimum latency:** valid_in[i] sampled at edge k produces valid_out=1 with that word after edge k+1 (2 edges).
- **Throughput:** one word per cycle while ready_out=1 and any FIFO is non-empty.
- **Fairness:** with all channels continuously non-empty and ready_out=1, the output channel order is 0,1,…,NUM_CH-1 repeating. Each channel gets 1 of every NUM_CH output words.
- **Output acceptance:** a word is accepted by downstream on any edge where valid_out=1 and ready_out=1.
- **Registered outputs:** fifo_full and overflow are registered and reflect post-edge state.

## Test plan
All scenarios use NUM_CH=4, DATA_W=4, FIFO_DEPTH=4.

- **Reset values:** hold reset_L=0 for 2 cycles with random inputs -> valid_out=0, data_out=0, ch_out=0, fifo_full=0, overflow=0 throughout.
- **Single-channel latency:** ready_out=1, one pulse valid_in=4'b0100 with ch2 data=4'hA at edge 5 -> after edge 6: valid_out=1, data_out=4'hA, ch_out=2; after edge 7: valid_out=0.
- **Round-robin order:** ready_out=1, one cycle valid_in=4'hF with data ch0..ch3=1,2,3,4 -> four consecutive outputs (ch,data)=(0,1),(1,2),(2,3),(3,4), then valid_out=0. A second burst starts at ch0 (rr_ptr=0).
- **Backpressure hold:**
  - Stimulus: ready_out=0 while ch1 writes 5,6,7.
  - Required: data_out=5 and ch_out=1 held for 10 cycles, fifo_full[1]=0.
  - Then raise ready_out: outputs 5,6,7 on consecutive cycles.
- **Overflow:**
  - Stimulus: ready_out=0; ch3 writes 6 words 8..D on consecutive cycles.
  - Required: word 8 goes to the output register and 9..C fill the FIFO, so fifo_full[3]=1. Word D is dropped and overflow[3]=1.
  - Then release ready_out: outputs 8,9,A,B,C only; overflow[3] remains 1.
- **Reset mid-operation:** with 3 words queued on ch0 and valid_out=1, pulse reset_L low between edges -> outputs clear immediately with no clock edge. After release, no queued word is ever emitted.
